// File: rtl/fetch_stall_ctrl_pkg.sv
// rtl/fetch_stall_ctrl_pkg.sv - shared pipeline constants and stall-controller state encoding
package fetch_stall_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] INT_VECTOR_ADDR = 16'h0004;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_INT_DRAIN  = 2'd1;
  localparam logic [1:0] ST_INT_VECTOR = 2'd2;

  typedef enum logic [1:0] {
    RUN        = ST_RUN,
    INT_DRAIN  = ST_INT_DRAIN,
    INT_VECTOR = ST_INT_VECTOR
  } state_e;

endpackage

// File: rtl/fetch_stall_ctrl_load_use_detect.sv
// rtl/fetch_stall_ctrl_load_use_detect.sv - load-use hazard comparator between EX and decode
module load_use_detect
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  output logic                  o_lu_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit   = i_id_rs1_used && (i_ex_rd == i_id_rs1);
  assign w_rs2_hit   = i_id_rs2_used && (i_ex_rd == i_id_rs2);
  assign o_lu_hazard = i_ex_mem_read && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - fetch/decode hold/flush, bubble insertion and interrupt drain sequencing
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_busy,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  branch_taken,
  input  logic                  irq,
  output logic                  fd_hold,
  output logic                  fd_flush,
  output logic                  pc_hold,
  output logic                  de_bubble,
  output logic                  pc_sel_int,
  output logic                  int_ack,
  output logic                  ret_sel_branch
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_br_seen;
  logic        w_br_seen_nxt;
  logic        w_lu_hazard;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detect (
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rd      (ex_rd),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_rs1_used(id_rs1_used),
    .i_id_rs2_used(id_rs2_used),
    .o_lu_hazard  (w_lu_hazard)
  );

  always_comb begin
    fd_hold        = 1'b0;
    fd_flush       = 1'b0;
    pc_hold        = 1'b0;
    de_bubble      = 1'b0;
    pc_sel_int     = 1'b0;
    int_ack        = 1'b0;
    ret_sel_branch = 1'b0;
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_br_seen_nxt  = r_br_seen;

    // A busy data memory freezes everything, including the drain count.
    if (mem_busy) begin
      fd_hold = 1'b1;
      pc_hold = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (w_lu_hazard) begin
            fd_hold   = 1'b1;
            pc_hold   = 1'b1;
            de_bubble = 1'b1;
          end else if (irq) begin
            w_state_nxt   = INT_DRAIN;
            w_cnt_nxt     = 4'(DRAIN_CYCLES);
            w_br_seen_nxt = 1'b0;
          end
        end
        INT_DRAIN: begin
          fd_flush  = 1'b1;
          pc_hold   = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
          if (branch_taken) begin
            de_bubble     = 1'b1;
            w_br_seen_nxt = 1'b1;
          end
          if (r_cnt == 4'd1) begin
            w_state_nxt = INT_VECTOR;
          end
        end
        INT_VECTOR: begin
          pc_sel_int     = 1'b1;
          int_ack        = 1'b1;
          fd_flush       = 1'b1;
          ret_sel_branch = r_br_seen || branch_taken;
          w_state_nxt    = RUN;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_cnt     <= 4'd0;
      r_br_seen <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_br_seen <= w_br_seen_nxt;
    end
  end

endmodule
